screen_scanner: RTL and testbench

//  Video scan-out for the 512x256 monochrome screen held in the shared 16-bit dual-port SRAM.

---
 rtl/screen_pkg.sv | 32 +++
 rtl/video_timing.sv | 58 +++++
 rtl/screen_scanner.sv | 140 ++++++++++++++
 tb/tb_screen_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared constants for the monochrome frame-buffer scan-out.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: VGA 640x480 timing, frame-buffer placement and geometry, counter and bus widths.
package screen_pkg;

    localparam int CNT_W  = 10;  // hc / vc counter width
    localparam int ADDR_W = 15;  // SRAM word address width
    localparam int WORD_W = 16;  // SRAM word width = pixels per fetch

    // Horizontal timing in pixel clocks (total 800)
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;

    // Vertical timing in lines (total 525)
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    // Frame buffer: word address of row 0 word 0, image size and placement on screen
    localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
    localparam int SCR_IMG_W    = 512;
    localparam int SCR_IMG_H    = 256;
    localparam int SCR_X_OFFSET = 64;
    localparam int SCR_Y_OFFSET = 112;

    localparam int WORDS_PER_ROW = SCR_IMG_W / WORD_W;

endpackage

// File: rtl/video_timing.sv
// video_timing: free-running hc/vc raster counters with raw sync, display-enable and vblank decode.
// Latency: decodes are combinational from the current counter values (caller registers them).
// Backpressure: none; counters advance every clock.
// Ports: clk/rst_n (async active-low); hc, vc counters; hsync_n, vsync_n, de, vblank, frame_start decodes.
module video_timing
    import screen_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             de,
    output logic             vblank,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign hsync_n     = !((hc >= HS_START) && (hc < HS_END));
    assign vsync_n     = !((vc >= VS_START) && (vc < VS_END));
    assign de          = (hc < H_VIS) && (vc < V_VIS);
    assign vblank      = (vc >= V_VIS);
    assign frame_start = (hc == '0) && (vc == V_VIS);

endmodule

// File: rtl/screen_scanner.sv
// screen_scanner: VGA scan-out of the monochrome frame buffer through read-only SRAM port B.
// Latency: all video outputs lag the raster counters by 1 clock; SRAM data is used 1 clock after o_addr.
// Backpressure: none; fixed-rate pixel stream, SRAM port B is owned by this block.
// Ports: i_clk, i_rst_n (async active-low), i_enable (0 blanks pixels), o_addr/i_data (SRAM port B),
//        o_hsync/o_vsync (active low), o_de, o_pixel (1 = ink, LSB leftmost), o_vblank, o_frame_start.
module screen_scanner
    import screen_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter logic [ADDR_W-1:0] SCREEN_BASE = SCR_BASE,
    parameter int IMG_W     = SCR_IMG_W,
    parameter int IMG_H     = SCR_IMG_H,
    parameter int X_OFFSET  = SCR_X_OFFSET,
    parameter int Y_OFFSET  = SCR_Y_OFFSET
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output logic              o_pixel,
    output logic              o_vblank,
    output logic              o_frame_start
);

    localparam int WPR = IMG_W / WORD_W;

    // Address for word w is on the bus during hc = X_OFFSET+16w-2, data arrives during
    // X_OFFSET+16w-1 and is captured at the end of that cycle, so the first pixel is
    // in sreg[0] exactly when hc reaches its screen column.
    localparam logic [CNT_W-1:0] FETCH_FIRST = CNT_W'(X_OFFSET - 2);
    localparam logic [CNT_W-1:0] LOAD_FIRST  = CNT_W'(X_OFFSET - 1);
    localparam logic [CNT_W-1:0] X_OFF_C     = CNT_W'(X_OFFSET);
    localparam logic [CNT_W-1:0] Y_OFF_C     = CNT_W'(Y_OFFSET);
    localparam logic [CNT_W-1:0] IMG_W_C     = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] IMG_H_C     = CNT_W'(IMG_H);

    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  vc;
    logic              raw_hsync_n;
    logic              raw_vsync_n;
    logic              raw_de;
    logic              raw_vblank;
    logic              raw_frame_start;

    logic [CNT_W-1:0]  hc_next;
    logic [CNT_W-1:0]  fetch_off;
    logic [CNT_W-1:0]  load_off;
    logic [CNT_W-1:0]  x_off;
    logic [CNT_W-1:0]  y_off;
    logic              line_in_image;
    logic              col_in_image;
    logic              fetch_due;
    logic              load_due;
    logic [ADDR_W-1:0] fetch_addr;
    logic [WORD_W-1:0] sreg;

    video_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .hc          (hc),
        .vc          (vc),
        .hsync_n     (raw_hsync_n),
        .vsync_n     (raw_vsync_n),
        .de          (raw_de),
        .vblank      (raw_vblank),
        .frame_start (raw_frame_start)
    );

    // Offsets are unsigned: positions left of / above an origin wrap to large values
    // and so fail the "< size" tests without a separate lower-bound compare.
    assign hc_next       = hc + 1'b1;
    assign fetch_off     = hc_next - FETCH_FIRST;
    assign load_off      = hc - LOAD_FIRST;
    assign x_off         = hc - X_OFF_C;
    assign y_off         = vc - Y_OFF_C;
    assign line_in_image = (y_off < IMG_H_C);
    assign col_in_image  = (x_off < IMG_W_C);

    // o_addr is registered, so it is updated one clock ahead of its fetch cycle (hc_next).
    // hc never wraps inside a line's fetch window, so vc is the same line.
    assign fetch_due  = line_in_image && (fetch_off < IMG_W_C) && (fetch_off[3:0] == 4'd0);
    assign load_due   = line_in_image && (load_off < IMG_W_C) && (load_off[3:0] == 4'd0);
    assign fetch_addr = SCREEN_BASE + (ADDR_W'(y_off) * ADDR_W'(WPR))
                      + ADDR_W'(fetch_off[CNT_W-1:4]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr <= SCREEN_BASE;
            sreg   <= '0;
        end else begin
            if (fetch_due) begin
                o_addr <= fetch_addr;
            end
            if (load_due) begin
                sreg <= i_data;
            end else begin
                sreg <= {1'b0, sreg[WORD_W-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_de          <= 1'b0;
            o_pixel       <= 1'b0;
            o_vblank      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_hsync       <= raw_hsync_n;
            o_vsync       <= raw_vsync_n;
            o_de          <= raw_de;
            o_pixel       <= sreg[0] & line_in_image & col_in_image & i_enable;
            o_vblank      <= raw_vblank;
            o_frame_start <= raw_frame_start;
        end
    end

endmodule

// File: tb/tb_screen_scanner.sv
// tb_screen_scanner: randomized self-checking bench for screen_scanner against a raster-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_screen_scanner;

    // Reduced geometry: a whole frame is 100 x 48 = 4800 clocks.
    localparam int HV = 80, HFP = 4, HS = 8, HBP = 8;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VV = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int IW = 48, IH = 16, XO = 16, YO = 12;
    localparam int WPR = IW / 16;
    localparam logic [14:0] BASE = 15'h4000;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_enable = 1'b1;
    logic [14:0] o_addr;
    logic [15:0] i_data;
    logic        o_hsync, o_vsync, o_de, o_pixel, o_vblank, o_frame_start;

    // SRAM port B: address registered, data read combinationally
    logic [15:0] mem [0:32767];
    logic [14:0] mem_addr_q = 15'h4000;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) mem_addr_q <= o_addr;
    assign i_data = mem[mem_addr_q];

    screen_scanner #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SCREEN_BASE (BASE), .IMG_W (IW), .IMG_H (IH),
        .X_OFFSET (XO), .Y_OFFSET (YO)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .o_addr        (o_addr),
        .i_data        (i_data),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_de          (o_de),
        .o_pixel       (o_pixel),
        .o_vblank      (o_vblank),
        .o_frame_start (o_frame_start)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: k = clock edges since reset release
    int          k;
    logic [14:0] exp_addr;
    bit          rand_en = 1'b0;
    int          hs_low, vs_low, de_hi, pix_hi, pix_last_k, first_hs_fall;
    int          fs_cnt, fs_first, fs_second;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", tag, k, got, exp);
        end
    endtask

    // Expected {hsync, vsync, de, vblank, frame_start, pixel} for raster position n
    function automatic logic [5:0] model_flags(input int n, input logic en);
        int h, v, x, y;
        logic [15:0] w;
        logic hs_n, vs_n, de_e, vb, fs, px;
        h    = n % HT;
        v    = (n / HT) % VT;
        x    = h - XO;
        y    = v - YO;
        hs_n = !(h >= HV + HFP && h < HV + HFP + HS);
        vs_n = !(v >= VV + VFP && v < VV + VFP + VS);
        de_e = (h < HV) && (v < VV);
        vb   = (v >= VV);
        fs   = (h == 0) && (v == VV);
        px   = 1'b0;
        if (x >= 0 && x < IW && y >= 0 && y < IH) begin
            w  = mem[BASE + y * WPR + x / 16];
            px = en & w[x % 16];
        end
        return {hs_n, vs_n, de_e, vb, fs, px};
    endfunction

    function automatic logic [5:0] dut_flags();
        return {o_hsync, o_vsync, o_de, o_vblank, o_frame_start, o_pixel};
    endfunction

    task automatic clear_model();
        k = 0; exp_addr = BASE;
        hs_low = 0; vs_low = 0; de_hi = 0; pix_hi = 0; pix_last_k = 0; first_hs_fall = 0;
        fs_cnt = 0; fs_first = 0; fs_second = 0;
    endtask

    // One clock: after edge k the outputs describe raster position k-1,
    // while the address register already belongs to raster position k.
    task automatic step();
        int   hi, vi;
        logic en_edge;
        @(posedge i_clk);
        k++;
        en_edge = i_enable;
        hi = k % HT;
        vi = (k / HT) % VT;
        if (vi >= YO && vi < YO + IH && hi >= XO - 2 && hi < XO - 2 + IW && ((hi - (XO - 2)) % 16) == 0)
            exp_addr = BASE + 15'((vi - YO) * WPR + (hi - (XO - 2)) / 16);
        @(negedge i_clk);
        check_val("flags", 32'(dut_flags()), 32'(model_flags(k - 1, en_edge)));
        check_val("addr", 32'(o_addr), 32'(exp_addr));
        if (!o_hsync) begin
            hs_low++;
            if (first_hs_fall == 0) first_hs_fall = k;
        end
        if (!o_vsync) vs_low++;
        if (o_de) de_hi++;
        if (o_pixel) begin
            pix_hi++;
            pix_last_k = k;
        end
        if (o_frame_start) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_first = k;
            else if (fs_cnt == 2) fs_second = k;
        end
        if (rand_en) i_enable = 1'($urandom_range(1, 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset right now (no clock edge needed), check, then hold it for two clocks.
    task automatic apply_reset(input string tag);
        i_rst_n = 1'b0;
        #1;
        check_val({tag, "_flags"}, 32'(dut_flags()), 32'(6'b110000));
        check_val({tag, "_addr"}, 32'(o_addr), 32'(BASE));
        repeat (2) @(negedge i_clk);
        check_val({tag, "_hold_flags"}, 32'(dut_flags()), 32'(6'b110000));
        check_val({tag, "_hold_addr"}, 32'(o_addr), 32'(BASE));
        clear_model();
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic fill_mem(input logic [15:0] val);
        for (int a = 0; a < IH * WPR; a++) mem[BASE + a] = val;
    endtask

    initial begin
        #2;
        // Phase 1: reset values, first hsync fall, single ink pixel at image origin
        apply_reset("rst0");
        fill_mem(16'h0000);
        mem[BASE] = 16'h0001;
        release_reset();
        run(HT * VT + HT);
        check_val("first_hs_fall", 32'(first_hs_fall), 32'(HV + HFP + 1));
        check_val("lsb_pix_cnt", 32'(pix_hi), 32'd1);
        check_val("lsb_pix_pos", 32'(pix_last_k), 32'(YO * HT + XO + 1));

        // Phase 2: MSB of first and last word of row 0
        apply_reset("rst1");
        fill_mem(16'h0000);
        mem[BASE] = 16'h8000;
        mem[BASE + WPR - 1] = 16'h8000;
        release_reset();
        run(HT * VT + HT);
        check_val("msb_pix_cnt", 32'(pix_hi), 32'd2);
        check_val("msb_pix_last", 32'(pix_last_k), 32'(YO * HT + XO + IW - 1 + 1));

        // Phase 3: solid image, one exact frame of timing statistics
        apply_reset("rst2");
        fill_mem(16'hFFFF);
        release_reset();
        run(HT * VT);
        check_val("hs_low_frame", 32'(hs_low), 32'(HS * VT));
        check_val("vs_low_frame", 32'(vs_low), 32'(VS * HT));
        check_val("de_hi_frame", 32'(de_hi), 32'(HV * VV));
        check_val("pix_hi_frame", 32'(pix_hi), 32'(IW * IH));
        check_val("fs_per_frame", 32'(fs_cnt), 32'd1);

        // Phase 4: same image with i_enable low
        apply_reset("rst3");
        i_enable = 1'b0;
        release_reset();
        run(HT * VT);
        check_val("dis_pix_hi", 32'(pix_hi), 32'd0);
        check_val("dis_hs_low", 32'(hs_low), 32'(HS * VT));
        check_val("dis_vs_low", 32'(vs_low), 32'(VS * HT));

        // Phase 5: random image and random enable, then mid-line reset and frame_start cadence
        apply_reset("rst4");
        for (int a = 0; a < IH * WPR; a++) mem[BASE + a] = 16'($urandom);
        i_enable = 1'b1;
        rand_en  = 1'b1;
        release_reset();
        run(HT * VT + HT);
        clear_model();
        apply_reset("rst5");
        release_reset();
        run(20 * HT + 30);
        apply_reset("midline");
        release_reset();
        while (fs_cnt < 2 && k < 2 * HT * VT + HT) step();
        check_val("fs_first", 32'(fs_first), 32'(VV * HT + 1));
        check_val("fs_period", 32'(fs_second - fs_first), 32'(HT * VT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
